// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: groups every non-clock/reset signal of the ALU command sequencer.
//   cmd_*        : command channel (valid/ready), operands, opcode and tag in
//   alu_a/b/sel  : registered operands issued to the combinational ALU
//   alu_result/carry : ALU outputs fed back for capture
//   rsp_*        : response channel (valid/ready) with result, carry, error flag, tag
//   level        : command FIFO occupancy, excluding the in-flight command
// Modport slave is the sequencer; modport master is the environment (producer, ALU, consumer).
interface alu_cmd_sequencer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [7:0]             cmd_a;
    logic [7:0]             cmd_b;
    logic [3:0]             cmd_sel;
    logic [TAG_W-1:0]       cmd_tag;
    logic [7:0]             alu_a;
    logic [7:0]             alu_b;
    logic [3:0]             alu_sel;
    logic [15:0]            alu_result;
    logic                   alu_carry;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [15:0]            rsp_result;
    logic                   rsp_carry;
    logic                   rsp_err;
    logic [TAG_W-1:0]       rsp_tag;
    logic [$clog2(DEPTH):0] level;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, alu_result, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_err,
               rsp_tag, level
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag, alu_result, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry, rsp_err,
               rsp_tag, level
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: in-order command FIFO in front of a combinational 8-bit ALU.
// Commands are buffered, issued one at a time from registered alu_* outputs, and the ALU
// result is captured one cycle later into a held valid/ready response. Divide-by-zero and
// unsupported opcodes return rsp_err=1 with zeroed result/carry.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_cmd_sequencer_if.slave (command, ALU, response channels and level)
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    alu_cmd_sequencer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned ENT_W = 20 + TAG_W;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   count_q;
    logic [7:0]         alu_a_q, alu_b_q;
    logic [3:0]         alu_sel_q;
    logic [TAG_W-1:0]   tag_q;
    logic               rsp_valid_q, rsp_carry_q, rsp_err_q;
    logic [15:0]        rsp_result_q;
    logic [TAG_W-1:0]   rsp_tag_q;

    logic               push, pop, capture, clear_rsp, err;
    logic [ENT_W-1:0]   head;

    // Ready depends on occupancy only; a same-cycle pop never frees a full FIFO early.
    assign bus.cmd_ready = (count_q != LVL_W'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head          = mem_q[rd_ptr_q];

    assign err = ((alu_sel_q == 4'b0011) && (alu_b_q == 8'h00)) || (alu_sel_q >= 4'b1010);

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        capture   = 1'b0;
        clear_rsp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    clear_rsp = 1'b1;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StExec;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Storage needs no reset: occupancy tracking alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_sel, bus.cmd_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + LVL_W'(push) - LVL_W'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                alu_a_q   <= head[ENT_W-1 -: 8];
                alu_b_q   <= head[ENT_W-9 -: 8];
                alu_sel_q <= head[TAG_W+3 -: 4];
                tag_q     <= head[TAG_W-1:0];
            end
            if (capture) begin
                rsp_valid_q  <= 1'b1;
                rsp_err_q    <= err;
                rsp_result_q <= err ? 16'h0000 : bus.alu_result;
                rsp_carry_q  <= err ? 1'b0 : bus.alu_carry;
                rsp_tag_q    <= tag_q;
            end else if (clear_rsp) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.level      = count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer with a behavioural ALU_8bit
// model closing the alu_* loop. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_cmd_sequencer_if #(.DEPTH(4), .TAG_W(4)) bus ();

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU_8bit model: returns {carry, result}.
    function automatic logic [16:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] s);
        logic [8:0]  t;
        logic [15:0] p;
        logic [16:0] r;
        t = '0;
        p = 16'(a) * 16'(b);
        r = {1'b1, 16'hDEAD};
        case (s)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; r = {t[8], 8'h00, t[7:0]}; end
            4'd1: begin t = {1'b0, a} - {1'b0, b}; r = {t[8], 8'h00, t[7:0]}; end
            4'd2: r = {1'b0, p};
            4'd3: r = (b == 8'h00) ? {1'b1, 16'hFFFF} : {1'b0, 8'h00, a / b};
            4'd4: r = {1'b0, 8'h00, a & b};
            4'd5: r = {1'b0, 8'h00, a | b};
            4'd6: r = {1'b0, 8'h00, a ^ b};
            4'd7: r = {1'b0, 8'h00, ~a};
            4'd8: r = {a[7], 8'h00, a << 1};
            4'd9: r = {a[0], 8'h00, a >> 1};
            default: r = {1'b1, 16'hDEAD};
        endcase
        return r;
    endfunction

    // Expected response: {err, carry, result}.
    function automatic logic [17:0] exp_rsp(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] s);
        if ((s == 4'd3 && b == 8'h00) || s >= 4'd10) return {1'b1, 17'h0};
        return {1'b0, alu_model(a, b, s)};
    endfunction

    assign {bus.alu_carry, bus.alu_result} = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    logic [7:0] va [16];
    logic [7:0] vb [16];
    logic [3:0] vs [16];
    logic [3:0] vt [16];
    int n, tx, rx, cyc, last_cyc;
    bit chk_gap;

    task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s, input logic [3:0] t);
        va[i] = a; vb[i] = b; vs[i] = s; vt[i] = t;
    endtask

    task automatic check_rsp(input int i);
        logic [17:0] e;
        e = exp_rsp(va[i], vb[i], vs[i]);
        check($sformatf("rsp%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
        check($sformatf("rsp%0d_result", i), 32'(bus.rsp_result), 32'(e[15:0]));
        check($sformatf("rsp%0d_carry", i), 32'(bus.rsp_carry), 32'(e[16]));
        check($sformatf("rsp%0d_err", i), 32'(bus.rsp_err), 32'(e[17]));
        check($sformatf("rsp%0d_tag", i), 32'(bus.rsp_tag), 32'(vt[i]));
    endtask

    // One cycle: offer the next command, check a response about to be consumed, clock.
    task automatic step();
        logic acc;
        if (tx < n) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = va[tx];
            bus.cmd_b     = vb[tx];
            bus.cmd_sel   = vs[tx];
            bus.cmd_tag   = vt[tx];
        end else begin
            bus.cmd_valid = 1'b0;
        end
        acc = bus.cmd_valid && bus.cmd_ready;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (rx < n) check_rsp(rx);
            else check("extra_rsp", 32'd1, 32'd0);
            if (chk_gap && rx > 0) check($sformatf("gap%0d", rx), 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
            rx++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) tx++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int seen;
        total = 0; bad = 0; cyc = 0; last_cyc = 0; chk_gap = 1'b0;
        n = 0; tx = 0; rx = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_sel = '0;
        bus.cmd_tag = '0; bus.rsp_ready = 1'b1;

        // Reset values
        #3;
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single command latency: accept at N, issue at N+1, response after N+2
        bus.cmd_valid = 1'b1; bus.cmd_a = 8'd10; bus.cmd_b = 8'd5; bus.cmd_sel = 4'd0;
        bus.cmd_tag = 4'd3;
        check("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("t1_level_n", 32'(bus.level), 32'd1);
        check("t1_valid_n", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t1_alu_a", 32'(bus.alu_a), 32'd10);
        check("t1_alu_b", 32'(bus.alu_b), 32'd5);
        check("t1_alu_sel", 32'(bus.alu_sel), 32'd0);
        check("t1_level_n1", 32'(bus.level), 32'd0);
        check("t1_valid_n1", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("t1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_result", 32'(bus.rsp_result), 32'h000F);
        check("t1_carry", 32'(bus.rsp_carry), 32'd0);
        check("t1_err", 32'(bus.rsp_err), 32'd0);
        check("t1_tag", 32'(bus.rsp_tag), 32'd3);
        tick();
        check("t1_valid_drop", 32'(bus.rsp_valid), 32'd0);

        // Back-to-back, all ten opcodes, 2-cycle spacing
        for (int i = 0; i < 10; i++) set_vec(i, 8'd10, 8'd5, 4'(i), 4'(i));
        n = 10; tx = 0; rx = 0; chk_gap = 1'b1;
        for (int c = 0; c < 80 && rx < n; c++) step();
        bus.cmd_valid = 1'b0; chk_gap = 1'b0;
        check("t2_count", 32'(rx), 32'd10);

        // Error overrides plus carry-producing vectors
        set_vec(0, 8'd10, 8'd0, 4'd3, 4'd10);
        set_vec(1, 8'd10, 8'd5, 4'd12, 4'd11);
        set_vec(2, 8'd200, 8'd100, 4'd0, 4'd12);
        set_vec(3, 8'd5, 8'd10, 4'd1, 4'd13);
        n = 4; tx = 0; rx = 0;
        for (int c = 0; c < 40 && rx < n; c++) step();
        bus.cmd_valid = 1'b0;
        check("t3_count", 32'(rx), 32'd4);

        // Backpressure: 5 of 6 accepted, response held, then in-order drain
        set_vec(0, 8'd3, 8'd4, 4'd0, 4'd1);
        set_vec(1, 8'd9, 8'd3, 4'd3, 4'd2);
        set_vec(2, 8'hF0, 8'h0F, 4'd5, 4'd3);
        set_vec(3, 8'd7, 8'd2, 4'd2, 4'd4);
        set_vec(4, 8'h81, 8'd0, 4'd8, 4'd5);
        set_vec(5, 8'h55, 8'hAA, 4'd6, 4'd6);
        n = 6; tx = 0; rx = 0; bus.rsp_ready = 1'b0;
        repeat (10) step();
        check("t4_accepted", 32'(tx), 32'd5);
        check("t4_level", 32'(bus.level), 32'd4);
        check("t4_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_rsp(0);
        repeat (3) step();
        check("t4_hold_accepted", 32'(tx), 32'd5);
        check_rsp(0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 60 && rx < n; c++) step();
        bus.cmd_valid = 1'b0;
        check("t4_count", 32'(rx), 32'd6);
        check("t4_all_accepted", 32'(tx), 32'd6);

        // Asynchronous reset mid-operation
        n = 4; tx = 0; rx = 0; bus.rsp_ready = 1'b0;
        repeat (8) step();
        bus.cmd_valid = 1'b0;
        check("t5_pre_level", 32'(bus.level), 32'd3);
        check("t5_pre_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_level", 32'(bus.level), 32'd0);
        check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("t5_alu_a", 32'(bus.alu_a), 32'd0);
        check("t5_alu_b", 32'(bus.alu_b), 32'd0);
        check("t5_alu_sel", 32'(bus.alu_sel), 32'd0);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_rsp_result", 32'(bus.rsp_result), 32'd0);
        check("t5_rsp_carry", 32'(bus.rsp_carry), 32'd0);
        check("t5_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("t5_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        check("t5_post_level", 32'(bus.level), 32'd0);
        check("t5_post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        check("t5_no_stale", 32'(seen), 32'd0);
        set_vec(0, 8'h12, 8'h34, 4'd4, 4'd9);
        n = 1; tx = 0; rx = 0;
        for (int c = 0; c < 20 && rx < n; c++) step();
        bus.cmd_valid = 1'b0;
        check("t5_after_count", 32'(rx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
